// File: rtl/led_matrix_pkg.sv
// Shared types, constants and the row-select decoder for the LED matrix scanner.
package led_matrix_pkg;

    localparam int MATRIX_DIM = 8;
    localparam int ROW_IDX_W  = 3;

    typedef logic [7:0] row_t;

    typedef enum logic [0:0] {
        SCAN_BLANK = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_e;

    // A row select is only a valid write address when exactly one bit is set.
    function automatic void onehot_idx(
        input  row_t                 row,
        output logic [ROW_IDX_W-1:0] idx,
        output logic                 valid
    );
        int unsigned ones;
        ones = 0;
        idx  = '0;
        for (int i = 0; i < MATRIX_DIM; i++) begin
            if (row[i]) begin
                ones = ones + 1;
                idx  = ROW_IDX_W'(i);
            end
        end
        valid = (ones == 1);
    endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// CPU-side capture inputs and LED-side drive outputs of the matrix scanner.
interface led_matrix_scan_if;
    import led_matrix_pkg::*;

    row_t col;
    row_t row;
    logic blank;
    row_t drive_row;
    row_t drive_col_n;
    logic frame_start;

    modport master (
        output col, row, blank,
        input  drive_row, drive_col_n, frame_start
    );

    modport slave (
        input  col, row, blank,
        output drive_row, drive_col_n, frame_start
    );

endinterface

// File: rtl/led_matrix_scan.sv
// 8x8 frame buffer capture plus blanked row-multiplexed scan of an LED matrix.
// Optional DOUBLE_BUFFER_EN: captures go to a back buffer copied to the front at each frame start.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic              clk,
    input  logic              reset,
    led_matrix_scan_if.slave  bus
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    scan_state_e            state_q, state_d;
    logic [ROW_IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    row_t                   drive_row_q, drive_row_d;
    row_t                   drive_col_n_q, drive_col_n_d;
    logic                   frame_start_q, frame_start_d;

    row_t [MATRIX_DIM-1:0]  wr_buf_q, wr_buf_d;
    row_t [MATRIX_DIM-1:0]  disp_buf;
    logic [ROW_IDX_W-1:0]   wr_idx;
    logic                   wr_valid;

    always_comb begin
        onehot_idx(bus.row, wr_idx, wr_valid);
        wr_buf_d = wr_buf_q;
        if (wr_valid) begin
            wr_buf_d[wr_idx] = bus.col;
        end
    end

`ifdef DOUBLE_BUFFER_EN
    row_t [MATRIX_DIM-1:0]  front_q, front_d;

    // The copy uses the pre-capture back buffer, so a same-cycle write waits a frame.
    always_comb begin
        front_d = frame_start_d ? wr_buf_q : front_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            front_q <= '0;
        end else begin
            front_q <= front_d;
        end
    end

    assign disp_buf = front_q;
`else
    assign disp_buf = wr_buf_q;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q - CNT_W'(1);
        frame_start_d = 1'b0;
        unique case (state_q)
            SCAN_BLANK: begin
                if (cnt_q == '0) begin
                    state_d = SCAN_DRIVE;
                    cnt_d   = DWELL_LOAD;
                end
            end
            SCAN_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d       = SCAN_BLANK;
                    cnt_d         = BLANK_LOAD;
                    idx_d         = idx_q + 3'd1;
                    frame_start_d = (idx_q == 3'd7);
                end
            end
            default: begin
                state_d = SCAN_BLANK;
                cnt_d   = BLANK_LOAD;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        drive_row_d   = '0;
        drive_col_n_d = 8'hFF;
        if (state_d == SCAN_DRIVE && !bus.blank) begin
            drive_row_d   = row_t'(8'h01) << idx_d;
            drive_col_n_d = ~disp_buf[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= SCAN_BLANK;
            idx_q         <= '0;
            cnt_q         <= BLANK_LOAD;
            drive_row_q   <= '0;
            drive_col_n_q <= 8'hFF;
            frame_start_q <= 1'b0;
            wr_buf_q      <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            drive_row_q   <= drive_row_d;
            drive_col_n_q <= drive_col_n_d;
            frame_start_q <= frame_start_d;
            wr_buf_q      <= wr_buf_d;
        end
    end

    assign bus.drive_row   = drive_row_q;
    assign bus.drive_col_n = drive_col_n_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with DWELL_CYCLES=4, BLANK_CYCLES=1 (row period 5).
module tb_led_matrix_scan;
    import led_matrix_pkg::*;

    localparam int DWELL  = 4;
    localparam int BLANK  = 1;
    localparam int PERIOD = DWELL + BLANK;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;
    int k           = 0;

    row_t [7:0] back_m;
`ifdef DOUBLE_BUFFER_EN
    row_t [7:0] front_m;
`endif

    led_matrix_scan_if bus_if ();

    led_matrix_scan #(
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at scan cycle %0d: observed %h, expected %h", tag, k, observed, expected);
        end
    endtask

    // Phase of scan cycle k after reset release: k=1 is row 0's first DRIVE cycle.
    task automatic applyStimulus(input int n);
        row_t in_row, in_col, disp, exp_row, exp_col;
        logic in_blank, in_reset, drv, fs;
        int   p, r, hot, hot_idx;
        for (int e = 0; e < n; e++) begin
            in_row   = bus_if.row;
            in_col   = bus_if.col;
            in_blank = bus_if.blank;
            in_reset = reset;
            @(posedge clk);
            if (!in_reset) begin
                k       = 0;
                back_m  = '0;
`ifdef DOUBLE_BUFFER_EN
                front_m = '0;
`endif
                exp_row = 8'h00;
                exp_col = 8'hFF;
                fs      = 1'b0;
            end else begin
                k   = k + 1;
                p   = (k - 1) % PERIOD;
                r   = ((k - 1) / PERIOD) % 8;
                drv = (p < DWELL);
                fs  = (p == DWELL) && (r == 7);
`ifdef DOUBLE_BUFFER_EN
                disp = front_m[r];
`else
                disp = back_m[r];
`endif
                exp_row = (drv && !in_blank) ? row_t'(8'h01 << r) : 8'h00;
                exp_col = (drv && !in_blank) ? ~disp : 8'hFF;
`ifdef DOUBLE_BUFFER_EN
                if (fs) front_m = back_m;
`endif
                hot     = 0;
                hot_idx = 0;
                for (int i = 0; i < 8; i++) begin
                    if (in_row[i]) begin
                        hot     = hot + 1;
                        hot_idx = i;
                    end
                end
                if (hot == 1) back_m[hot_idx] = in_col;
            end
            @(negedge clk);
            checkOutput("drive_row", bus_if.drive_row, exp_row);
            checkOutput("drive_col_n", bus_if.drive_col_n, exp_col);
            checkOutput("frame_start", {7'b0, bus_if.frame_start}, {7'b0, fs});
        end
    endtask

    task automatic waitFor(input int target_row, input int target_phase);
        logic found;
        found = 1'b0;
        for (int e = 0; e < 60 && !found; e++) begin
            if (k > 0 && ((k - 1) % PERIOD) == target_phase && (((k - 1) / PERIOD) % 8) == target_row)
                found = 1'b1;
            else
                applyStimulus(1);
        end
        checkOutput("sync", {7'b0, found}, 8'h01);
    endtask

    task automatic writeRow(input row_t sel, input row_t pattern);
        bus_if.row = sel;
        bus_if.col = pattern;
        applyStimulus(1);
        bus_if.row = 8'h00;
        bus_if.col = 8'h00;
    endtask

    initial begin
        reset        = 1'b0;
        bus_if.row   = 8'h00;
        bus_if.col   = 8'h00;
        bus_if.blank = 1'b0;
        applyStimulus(3);

        reset = 1'b1;
        applyStimulus(45);

        writeRow(8'h04, 8'hA5);
        applyStimulus(45);

        // Multi-hot select must not disturb rows 1 or 2.
        writeRow(8'h06, 8'hFF);
        applyStimulus(45);

        waitFor(2, 1);
        writeRow(8'h04, 8'h3C);
        applyStimulus(45);

        waitFor(2, 4);
        bus_if.blank = 1'b1;
        applyStimulus(4);
        bus_if.blank = 1'b0;
        applyStimulus(10);

        waitFor(5, 1);
        reset = 1'b0;
        applyStimulus(1);
        reset = 1'b1;
        applyStimulus(12);

        waitFor(0, 1);
        writeRow(8'h01, 8'h3C);
        applyStimulus(45);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Downstream display stage for the 4-bit CPU: captures the CPU's `col`/`row` outputs into an 8x8 frame buffer and time-multiplexes it onto the physical LED matrix. One row is driven at a time, with a programmable dwell and an inter-row blanking gap to suppress ghosting. A one-cycle frame marker is produced at each frame start, and an optional double buffer gives tear-free updates.

## Interface
Parameters:
- `DWELL_CYCLES`, default 1000: cycles each row is lit; minimum 1.
- `BLANK_CYCLES`, default 50: all-off cycles before each row; minimum 1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- `col`  in  8  CPU column pattern; bit c=1 lights column c.
- `row`  in  8  CPU row select; a one-hot value addresses a buffer row.
- `blank`  in  1  when 1, forces outputs off; scanning continues.
- `drive_row`  out  8  one-hot active-high row drive.
- `drive_col_n`  out  8  active-low column drive.
- `frame_start`  out  1  one-cycle pulse when row 0 enters BLANK.

## Operation
- Capture
  - Each cycle in which `row` has exactly one bit set at index k, `buf[k] <= col`.
  - If `row` is 0 or multi-hot, nothing is written.
  - `col` has no other effect.
- Scan FSM has two states.
  - BLANK: `drive_row=0`, `drive_col_n=8'hFF`; stays for `BLANK_CYCLES` cycles, then goes to DRIVE.
  - DRIVE: `drive_row=1<<idx`, `drive_col_n=~buf_front[idx]`; stays for `DWELL_CYCLES` cycles, then goes to BLANK with `idx <= idx+1`.
  - `idx` is 3 bits and wraps 7->0.
- `frame_start` pulses for 1 cycle on the DRIVE->BLANK transition from idx 7 to idx 0. It does not pulse at reset exit.
- `blank=1` forces `drive_row=0` and `drive_col_n=8'hFF` on the next cycle. The FSM, counters and `frame_start` keep running unaffected.
- Cycle counter
  - Single down-counter, width `$clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1)`.
  - Loaded with N-1 on state entry; the state transitions when it reaches 0.
  - No overflow is possible.
- Without `DOUBLE_BUFFER_EN`, `buf_front` is `buf`, so a write to the currently driven row is visible on `drive_col_n` 1 cycle later.

## Timing
- All outputs are registered.
- Reset values: state BLANK, idx 0, counter `BLANK_CYCLES-1`, all buffers 0, `drive_row=0`, `drive_col_n=8'hFF`, `frame_start=0`.
- After `reset` deasserts, the first `drive_row=8'h01` appears after exactly `BLANK_CYCLES` clock edges.
- Row period is `BLANK_CYCLES+DWELL_CYCLES`; frame period is 8x the row period.
- Reset asserted mid-frame returns every register to its reset value on that edge, including buffer contents.
- A capture and a scan read of the same row in the same cycle: the output shows the old value that cycle and the new value the next cycle.

## Configuration
- `DOUBLE_BUFFER_EN` defined
  - Captures write a back buffer only.
  - On the cycle `frame_start` is asserted, the front buffer is loaded with all 8 rows of the back buffer.
  - A capture on that same cycle lands in the back buffer only and is displayed from the following frame.
  - Display never changes mid-frame.
- Undefined: a single buffer with the immediate visibility described above. The back-buffer registers are not synthesised.

## Structure
- `led_matrix_pkg` holds:
  - the scan state enum (`SCAN_BLANK`, `SCAN_DRIVE`);
  - `MATRIX_DIM = 8` and `ROW_IDX_W = 3`;
  - a `row_t` typedef (`logic [7:0]`);
  - function `onehot_idx(row, idx, valid)`, used by capture.
- No sub-module. FSM, counter and buffer all live in `led_matrix_scan`.

## Test plan
Run with `DWELL_CYCLES=4`, `BLANK_CYCLES=1`; the row period is 5.
- Reset release with `row=0`:
  - `drive_row=0` and `drive_col_n=FF` for 1 cycle, then `drive_row=01` for 4 cycles, then 0 for 1 cycle, then `02`.
  - After 40 cycles, `frame_start` pulses once.
- Write `row=8'h04`, `col=8'hA5` for 1 cycle: when row 2 is driven, `drive_col_n=8'h5A`. Rows not written show `FF`.
- Multi-hot `row=8'h06` with `col=8'hFF`: no buffer change; rows 1 and 2 keep their previous contents.
- `blank=1` held over row 3's DRIVE window: outputs are off, and row 4 still starts on schedule, 5 cycles after row 3 started.
- Reset pulsed in the middle of row 5's DRIVE: next cycle outputs are `00`/`FF`, the buffer is cleared, and the scan restarts at row 0 after 1 cycle.
- `DOUBLE_BUFFER_EN`: write `row=01`, `col=3C` while row 0 is driven; `drive_col_n` stays `FF` until after the next `frame_start`, then shows `C3`.
